// File: rtl/serial_adder64b_pkg.sv
// Shared constants for the byte-serial ALU adder path.
// State encoding and byte width used by serial_adder64b.
package serial_adder64b_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder64b_cla.sv
// 8-bit carry look-ahead adder used as the per-byte datapath
// of the serial adder.
module cla_adder8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_i,
    output logic [7:0] s,
    output logic       c_o
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = c_i;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s   = p ^ c[7:0];
    assign c_o = c[8];

endmodule

// File: rtl/serial_adder64b.sv
// Byte-serial adder/subtractor: one byte per cycle through a single
// cla_adder8b, carry chained through a register between bytes.
module serial_adder64b
    import serial_adder64b_pkg::*;
#(
    parameter int N_BYTES = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      sub,
    input  logic [BYTE_W*N_BYTES-1:0] a,
    input  logic [BYTE_W*N_BYTES-1:0] b,
    output logic [BYTE_W*N_BYTES-1:0] s,
    output logic                      c_o,
    output logic                      overflow,
    output logic                      busy,
    output logic                      done
);

    localparam int W  = BYTE_W * N_BYTES;
    localparam int CW = $clog2(N_BYTES);

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic              carry;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic [W-1:0]      acc;
    logic [W-1:0]      acc_nxt;
    logic [BYTE_W-1:0] byte_sum;
    logic              byte_co;
    logic              last;

    assign last = (count == CW'(N_BYTES - 1));

    cla_adder8b u_cla (
        .a   (a_r[count*BYTE_W +: BYTE_W]),
        .b   (b_r[count*BYTE_W +: BYTE_W]),
        .c_i (carry),
        .s   (byte_sum),
        .c_o (byte_co)
    );

    // Accumulator with the current byte merged in; on the last byte
    // this is the complete result.
    always_comb begin
        acc_nxt = acc;
        acc_nxt[count*BYTE_W +: BYTE_W] = byte_sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            carry    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            s        <= '0;
            c_o      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub;
                        count <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_nxt;
                    carry <= byte_co;
                    count <= count + CW'(1);
                    if (last) begin
                        s        <= acc_nxt;
                        c_o      <= byte_co;
                        overflow <= (a_r[W-1] == b_r[W-1]) &&
                                    (acc_nxt[W-1] != a_r[W-1]);
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder64b.sv
// Directed and random scoreboard bench for serial_adder64b.
// Expected results are queued at start and checked on done.
module tb_serial_adder64b;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [63:0] s;
    logic        c_o;
    logic        overflow;
    logic        busy;
    logic        done;

    int   n_assert = 0;
    int   n_fail = 0;
    exp_t q[$];
    logic [63:0] prev_s = '0;

    always #5 clk = ~clk;

    serial_adder64b #(.N_BYTES(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .s        (s),
        .c_o      (c_o),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    function automatic exp_t model(logic [63:0] x, logic [63:0] y,
                                   logic sb);
        exp_t        e;
        logic [64:0] f;
        if (sb)
            f = {1'b0, x} + {1'b0, ~y} + 65'd1;
        else
            f = {1'b0, x} + {1'b0, y};
        e.s = f[63:0];
        e.c = f[64];
        if (sb)
            e.ov = (x[63] != y[63]) && (e.s[63] != x[63]);
        else
            e.ov = (x[63] == y[63]) && (e.s[63] != x[63]);
        return e;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on every done, and s may only move at done
    always @(negedge clk) begin
        if (reset) begin
            prev_s = s;
        end else begin
            if (done) begin
                check("done_expected", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("s", s, e.s);
                    check("c_o", 64'(c_o), 64'(e.c));
                    check("overflow", 64'(overflow), 64'(e.ov));
                end
            end else if (s !== prev_s) begin
                check("s_stable", s, prev_s);
            end
            prev_s = s;
        end
    end

    // Drive a request at the falling edge; return just after the
    // accepting rising edge with start dropped.
    task automatic start_op(logic [63:0] x, logic [63:0] y, logic sb,
                            bit push);
        @(negedge clk);
        a = x;
        b = y;
        sub = sb;
        start = 1'b1;
        if (push) q.push_back(model(x, y, sb));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int lat);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 20);
        check("done_seen", 64'(done), 64'd1);
        check("latency", 64'(cyc), 64'(lat));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_s", s, 64'd0);
        check("rst_c_o", 64'(c_o), 64'd0);
        check("rst_ov", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        start_op(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1);
        check("busy_after_start", 64'(busy), 64'd1);
        wait_done(8);
        check("busy_in_done", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);

        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1);
        wait_done(8);
        start_op(64'd5, 64'd7, 1'b1, 1);
        wait_done(8);
        start_op(64'd7, 64'd5, 1'b1, 1);
        wait_done(8);

        // start while busy is ignored
        start_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        a = 64'hDEAD_BEEF_0000_0000;
        b = 64'h5555_5555_5555_5555;
        sub = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6);

        // back-to-back accept during the done cycle
        a = 64'h8000_0000_0000_0000;
        b = 64'h0000_0000_0000_0001;
        sub = 1'b1;
        start = 1'b1;
        q.push_back(model(a, b, sub));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done(8);

        // asynchronous reset mid-run discards the operation
        start_op(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b0, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_s", s, 64'd0);
        check("mid_rst_c_o", 64'(c_o), 64'd0);
        check("mid_rst_ov", 64'(overflow), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("no_done_after_rst", 64'(done), 64'd0);

        start_op(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1);
        wait_done(8);

        for (int i = 0; i < 1000; i++) begin
            logic [63:0] x;
            logic [63:0] y;
            x = {$urandom(), $urandom()};
            y = {$urandom(), $urandom()};
            if (i % 50 == 0) y = ~x;
            start_op(x, y, i[0], 1);
            wait_done(8);
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
